// File: rtl/proc_control_unit.sv
// proc_control_unit
//   Multi-cycle control unit for the 16-bit processor. Owns the program
//   counter and the instruction register. Fetches from a synchronous ROM,
//   decodes each instruction and sequences the register-file, data-memory
//   and ALU controls.
//
// Ports
//   Clk         rising-edge clock
//   ResetN      asynchronous active-low reset
//   IR_in       instruction-ROM read data (registered ROM, 1-cycle latency)
//   PC_Addr     instruction-ROM address (PC register)
//   IR_out      instruction register (debug)
//   State_out   state encoding (debug)
//   D_Addr      data-memory address
//   D_Wr        data-memory write enable
//   RF_s        RF write-data mux select (1 = data memory, 0 = ALU)
//   RF_W_Addr   RF write address
//   RF_W_en     RF write enable
//   RF_Ra_Addr  RF read port A address (ALU A)
//   RF_Rb_Addr  RF read port B address (ALU B)
//   ALU_sel     ALU op select
//   Halted      high while in Halt
module proc_control_unit #(
  parameter int pc_bits = 8
) (
  input  logic               Clk,
  input  logic               ResetN,
  input  logic [15:0]        IR_in,
  output logic [pc_bits-1:0] PC_Addr,
  output logic [15:0]        IR_out,
  output logic [3:0]         State_out,
  output logic [7:0]         D_Addr,
  output logic               D_Wr,
  output logic               RF_s,
  output logic [3:0]         RF_W_Addr,
  output logic               RF_W_en,
  output logic [3:0]         RF_Ra_Addr,
  output logic [3:0]         RF_Rb_Addr,
  output logic [2:0]         ALU_sel,
  output logic               Halted
);

  localparam logic [3:0] st_init   = 4'd0;
  localparam logic [3:0] st_fetch  = 4'd1;
  localparam logic [3:0] st_decode = 4'd2;
  localparam logic [3:0] st_noop   = 4'd3;
  localparam logic [3:0] st_load_a = 4'd4;
  localparam logic [3:0] st_load_b = 4'd5;
  localparam logic [3:0] st_store  = 4'd6;
  localparam logic [3:0] st_alu    = 4'd7;
  localparam logic [3:0] st_halt   = 4'd8;

  logic [3:0]         state_reg, state_next;
  logic [pc_bits-1:0] pc_reg;
  logic [15:0]        ir_reg;
  logic [3:0]         op;
  logic [2:0]         alu_sel_dec;

  assign op = ir_reg[15:12];

  // State, PC and IR. PC and IR only move at the end of Fetch.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_reg <= st_init;
      pc_reg    <= '0;
      ir_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == st_fetch) begin
        ir_reg <= IR_in;
        pc_reg <= pc_reg + pc_bits'(1);  // wraps silently
      end
    end
  end

  // ALU op select by opcode; zero for anything that is not an ALU op.
  always_comb begin
    alu_sel_dec = 3'd0;
    case (op)
      4'h3:    alu_sel_dec = 3'd1;  // ADD
      4'h4:    alu_sel_dec = 3'd2;  // SUB
      4'h6:    alu_sel_dec = 3'd4;  // XOR
      4'h7:    alu_sel_dec = 3'd5;  // OR
      4'h8:    alu_sel_dec = 3'd6;  // AND
      4'h9:    alu_sel_dec = 3'd7;  // INC
      default: alu_sel_dec = 3'd0;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      st_init:   state_next = st_fetch;
      st_fetch:  state_next = st_decode;
      st_decode: begin
        case (op)
          4'h1:                                   state_next = st_store;
          4'h2:                                   state_next = st_load_a;
          4'h3, 4'h4, 4'h6, 4'h7, 4'h8, 4'h9:     state_next = st_alu;
          4'h5:                                   state_next = st_halt;
          default:                                state_next = st_noop;  // NOOP and undefined
        endcase
      end
      st_load_a: state_next = st_load_b;
      st_noop, st_load_b, st_store, st_alu: state_next = st_fetch;
      st_halt:   state_next = st_halt;
      default:   state_next = st_init;
    endcase
  end

  // Control outputs decoded from state and IR only.
  always_comb begin
    D_Addr     = 8'd0;
    D_Wr       = 1'b0;
    RF_s       = 1'b0;
    RF_W_Addr  = 4'd0;
    RF_W_en    = 1'b0;
    RF_Ra_Addr = 4'd0;
    RF_Rb_Addr = 4'd0;
    ALU_sel    = 3'd0;
    Halted     = 1'b0;
    case (state_reg)
      st_store: begin
        D_Addr     = ir_reg[7:0];
        RF_Ra_Addr = ir_reg[11:8];
        D_Wr       = 1'b1;
      end
      // Synchronous data memory: address held across both load states,
      // the RF capture happens at the end of Load_B.
      st_load_a, st_load_b: begin
        D_Addr    = ir_reg[11:4];
        RF_s      = 1'b1;
        RF_W_Addr = ir_reg[3:0];
        RF_W_en   = (state_reg == st_load_b);
      end
      st_alu: begin
        RF_Ra_Addr = ir_reg[11:8];
        RF_Rb_Addr = ir_reg[7:4];
        RF_W_Addr  = ir_reg[3:0];
        ALU_sel    = alu_sel_dec;
        RF_W_en    = 1'b1;
      end
      st_halt:  Halted = 1'b1;
      default:  ;
    endcase
  end

  assign PC_Addr   = pc_reg;
  assign IR_out    = ir_reg;
  assign State_out = state_reg;

endmodule

// File: tb/tb_proc_control_unit.sv
module tb_proc_control_unit;

  logic        Clk = 1'b0;
  logic        ResetN = 1'b0;
  logic [15:0] IR_in = 16'h0000;
  logic [7:0]  PC_Addr;
  logic [15:0] IR_out;
  logic [3:0]  State_out;
  logic [7:0]  D_Addr;
  logic        D_Wr;
  logic        RF_s;
  logic [3:0]  RF_W_Addr;
  logic        RF_W_en;
  logic [3:0]  RF_Ra_Addr;
  logic [3:0]  RF_Rb_Addr;
  logic [2:0]  ALU_sel;
  logic        Halted;

  int total = 0;
  int bad   = 0;

  logic [15:0] rom [256];
  logic [7:0]  pc_m;     // model program counter
  logic [15:0] prev_w;   // model instruction register before the current Fetch

  proc_control_unit #(.pc_bits(8)) dut (
    .Clk(Clk), .ResetN(ResetN), .IR_in(IR_in),
    .PC_Addr(PC_Addr), .IR_out(IR_out), .State_out(State_out),
    .D_Addr(D_Addr), .D_Wr(D_Wr), .RF_s(RF_s),
    .RF_W_Addr(RF_W_Addr), .RF_W_en(RF_W_en),
    .RF_Ra_Addr(RF_Ra_Addr), .RF_Rb_Addr(RF_Rb_Addr),
    .ALU_sel(ALU_sel), .Halted(Halted)
  );

  always #5 Clk = ~Clk;

  // Registered instruction ROM.
  always @(posedge Clk) IR_in <= rom[PC_Addr];

  function automatic logic [31:0] pack(input logic [3:0] st, input logic [7:0] da,
                                       input logic dw, input logic rs, input logic [3:0] wa,
                                       input logic we, input logic [3:0] ra, input logic [3:0] rb,
                                       input logic [2:0] sel, input logic h);
    return {1'b0, st, da, dw, rs, wa, we, ra, rb, sel, h};
  endfunction

  function automatic logic [31:0] observed();
    return pack(State_out, D_Addr, D_Wr, RF_s, RF_W_Addr, RF_W_en,
                RF_Ra_Addr, RF_Rb_Addr, ALU_sel, Halted);
  endfunction

  // Instruction classes derived from the opcode table.
  function automatic int kind(input logic [15:0] w);
    case (w[15:12])
      4'h1: return 1;                                   // store
      4'h2: return 2;                                   // load
      4'h5: return 3;                                   // halt
      4'h3, 4'h4, 4'h6, 4'h7, 4'h8, 4'h9: return 4;     // alu
      default: return 0;                                // noop / undefined
    endcase
  endfunction

  function automatic int n_cycles(input logic [15:0] w);
    case (kind(w))
      2: return 4;
      3: return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [2:0] alu_code(input logic [3:0] op);
    logic [3:0] ops [6] = '{4'h3, 4'h4, 4'h6, 4'h7, 4'h8, 4'h9};
    logic [2:0] sels [6] = '{3'd1, 3'd2, 3'd4, 3'd5, 3'd6, 3'd7};
    for (int k = 0; k < 6; k++) if (ops[k] == op) return sels[k];
    return 3'd0;
  endfunction

  // Expected control outputs for cycle p of instruction w (0 = Fetch).
  function automatic logic [31:0] expect_out(input logic [15:0] w, input int p);
    if (p == 0) return pack(4'd1, 8'd0, 0, 0, 4'd0, 0, 4'd0, 4'd0, 3'd0, 0);
    if (p == 1) return pack(4'd2, 8'd0, 0, 0, 4'd0, 0, 4'd0, 4'd0, 3'd0, 0);
    case (kind(w))
      1: return pack(4'd6, w[7:0], 1, 0, 4'd0, 0, w[11:8], 4'd0, 3'd0, 0);
      2: return pack((p == 2) ? 4'd4 : 4'd5, w[11:4], 0, 1, w[3:0], (p == 3), 4'd0, 4'd0, 3'd0, 0);
      3: return pack(4'd8, 8'd0, 0, 0, 4'd0, 0, 4'd0, 4'd0, 3'd0, 1);
      4: return pack(4'd7, 8'd0, 0, 0, w[3:0], 1, w[11:8], w[7:4], alu_code(w[15:12]), 0);
      default: return pack(4'd3, 8'd0, 0, 0, 4'd0, 0, 4'd0, 4'd0, 3'd0, 0);
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check one cycle of an instruction at the negative edge.
  task automatic check_phase(input logic [15:0] w, input int p);
    logic [7:0] pc_n;
    pc_n = pc_m + 8'd1;
    @(negedge Clk);
    check($sformatf("outs w=%h p=%0d", w, p), observed(), expect_out(w, p));
    check($sformatf("pc w=%h p=%0d", w, p), {24'd0, PC_Addr}, {24'd0, (p == 0) ? pc_m : pc_n});
    check($sformatf("ir w=%h p=%0d", w, p), {16'd0, IR_out}, {16'd0, (p == 0) ? prev_w : w});
  endtask

  task automatic run_instr();
    logic [15:0] w;
    w = rom[pc_m];
    for (int p = 0; p < n_cycles(w); p++) check_phase(w, p);
    $display("instr pc=%02h w=%04h cycles=%0d", pc_m, w, n_cycles(w));
    pc_m   = pc_m + 8'd1;
    prev_w = w;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " outs"}, observed(), 32'd0);
    check({tag, " pc"}, {24'd0, PC_Addr}, 32'd0);
    check({tag, " ir"}, {16'd0, IR_out}, 32'd0);
  endtask

  initial begin
    logic [15:0] dir [9] = '{16'h2A53, 16'h1712, 16'h3125, 16'h4125, 16'h6125,
                             16'h7125, 16'h8125, 16'h9125, 16'hF000};
    logic [31:0] r;
    logic [3:0]  op;
    for (int i = 0; i < 256; i++) begin
      r  = $urandom;
      op = r[15:12];
      if (op == 4'h5) op = 4'h0;   // keep HALT out of the random program
      rom[i] = {op, r[11:0]};
    end
    for (int i = 0; i < 9; i++) rom[i] = dir[i];

    // Reset held across clock edges.
    repeat (3) @(negedge Clk);
    check_reset_state("reset_hold");
    ResetN = 1'b1;
    #1 check_reset_state("init");
    pc_m   = 8'd0;
    prev_w = 16'h0000;

    // Directed instructions, random program, and PC wrap past 255.
    for (int i = 0; i < 260; i++) run_instr();

    // HALT: PC and state frozen.
    rom[pc_m] = 16'h5000;
    begin
      logic [15:0] w;
      logic [7:0]  pc_frozen;
      w = rom[pc_m];
      check_phase(w, 0);
      check_phase(w, 1);
      pc_frozen = pc_m + 8'd1;
      for (int c = 0; c < 25; c++) begin
        @(negedge Clk);
        check($sformatf("halt c=%0d", c), observed(), expect_out(w, 2));
        check($sformatf("halt pc c=%0d", c), {24'd0, PC_Addr}, {24'd0, pc_frozen});
      end
      $display("instr pc=%02h w=%04h halted", pc_m, w);
    end

    // Reset out of Halt, then abort a STORE mid-instruction.
    ResetN = 1'b0;
    #1 check_reset_state("reset_from_halt");
    rom[0] = 16'h1712;
    @(negedge Clk);
    ResetN = 1'b1;
    pc_m   = 8'd0;
    prev_w = 16'h0000;
    check_phase(16'h1712, 0);
    check_phase(16'h1712, 1);
    check_phase(16'h1712, 2);
    #2 ResetN = 1'b0;
    #1 check_reset_state("store_abort");
    $display("instr pc=00 w=1712 aborted by reset");
    @(negedge Clk);
    check_reset_state("store_abort_hold");

    // Recovery after reset.
    ResetN = 1'b1;
    pc_m   = 8'd0;
    prev_w = 16'h0000;
    run_instr();
    run_instr();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
